// File: rtl/sha256_w_mem.sv
// ============================================================================
// Module   : sha256_w_mem
// Brief    : SHA-256 message-schedule generator with a 16-word sliding window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_w_mem #(
    parameter int NUM_ROUNDS = 64,
    parameter int CTR_W      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [511:0]     block,
    input  logic             w_init,
    input  logic             w_next,
    output logic [31:0]      w,
    output logic [CTR_W-1:0] w_ctr,
    output logic             w_last
);

    localparam logic [CTR_W-1:0] C_LAST    = CTR_W'(NUM_ROUNDS - 1);
    localparam logic [CTR_W-1:0] C_SIXTEEN = CTR_W'(16);
    localparam logic [CTR_W-1:0] C_ONE     = CTR_W'(1);

    logic [31:0]      mem_q [16];
    logic [31:0]      mem_d [16];
    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    logic [31:0]      w_blk [16];
    logic [31:0]      w_new;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_blk_words
        assign w_blk[gi] = block[511-32*gi -: 32];
    end

    assign w_new  = f_s1(mem_q[14]) + mem_q[9] + f_s0(mem_q[1]) + mem_q[0];
    assign w      = (ctr_q < C_SIXTEEN) ? mem_q[ctr_q[3:0]] : w_new;
    assign w_ctr  = ctr_q;
    assign w_last = (ctr_q == C_LAST);

    always_comb begin
        ctr_d = ctr_q;
        for (int i = 0; i < 16; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (w_init) begin
            ctr_d = '0;
            for (int i = 0; i < 16; i++) begin
                mem_d[i] = w_blk[i];
            end
        end else if (w_next && (ctr_q != C_LAST)) begin
            ctr_d = ctr_q + C_ONE;
            // Beyond index 15 the window slides so mem keeps W[t-16..t-1].
            if (ctr_q >= C_SIXTEEN) begin
                for (int i = 0; i < 15; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
                mem_d[15] = w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr_q <= '0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ctr_q <= ctr_d;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

`default_nettype wire
